// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game: flash sequencer state encoding,
// default LED bank geometry and the pair-mask helper that the game FSM
// also uses when comparing switch entries against the flashed pairs.
package memory_game_pkg;

    localparam int LED_W_DEF = 16;
    localparam int IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } flash_state_t;

    // One-hot OR of two LED indices; equal indices light a single LED.
    function automatic logic [LED_W_DEF-1:0] pair_mask(
        input logic [IDX_W_DEF-1:0] a,
        input logic [IDX_W_DEF-1:0] b
    );
        return (LED_W_DEF'(1) << a) | (LED_W_DEF'(1) << b);
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter shared by the on-time and the dark gap.
// A load always wins; otherwise the count decrements and parks at zero,
// so it never wraps. expired is a decode of the registered count.
module flash_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Count register: reload on request, otherwise run down to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/flash_sequencer.sv
// flash_sequencer: plays the memorisation phase of the memory game.
// On start it latches NUM_PAIRS index pairs and lights each pair on the
// red LED bank for ON_CYCLES, then pulses done for one cycle.
//
// Build option FLASH_SEQ_GAP_EN: when defined, each pair is followed by
// OFF_CYCLES of dark gap (GAP state). When undefined the next pair's mask
// is driven at the very edge the previous on-time expires.
//
// Handshake: start is a level sampled only in IDLE; abort is honoured in
// every state and outranks start and any timer expiry; done is a one-cycle
// pulse with busy already low in that cycle. No queuing of start.
//
// The state output exposes the FSM for observation. LED_W must equal
// 2**IDX_W and match the package defaults used by pair_mask.
module flash_sequencer
    import memory_game_pkg::*;
#(
    parameter int NUM_PAIRS  = 3,
    parameter int LED_W      = LED_W_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_PAIRS*IDX_W-1:0] idx_a,
    input  logic [NUM_PAIRS*IDX_W-1:0] idx_b,
    output logic [LED_W-1:0]           led,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 pair_num,
    output flash_state_t               state
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
`ifdef FLASH_SEQ_GAP_EN
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
`endif
    localparam logic [2:0] LAST_PAIR = 3'(NUM_PAIRS - 1);

    flash_state_t               state_n;
    logic [LED_W-1:0]           led_n;
    logic                       busy_n;
    logic                       done_n;
    logic [2:0]                 pair_num_n;

    logic [NUM_PAIRS*IDX_W-1:0] lat_a;
    logic [NUM_PAIRS*IDX_W-1:0] lat_b;
    logic                       latch_en;

    logic                       tmr_load;
    logic [TMR_W-1:0]           tmr_val;
    logic                       tmr_expired;

    logic [2:0]                 nxt_idx;
    logic [IDX_W-1:0]           nxt_a;
    logic [IDX_W-1:0]           nxt_b;
    logic [LED_W-1:0]           nxt_mask;
    logic [LED_W-1:0]           first_mask;

    flash_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Select the indices of the pair that follows the one currently shown.
    always_comb begin
        nxt_idx = pair_num + 3'd1;
        nxt_a   = '0;
        nxt_b   = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (nxt_idx == 3'(k)) begin
                nxt_a = lat_a[k*IDX_W +: IDX_W];
                nxt_b = lat_b[k*IDX_W +: IDX_W];
            end
        end
    end

    assign nxt_mask   = pair_mask(nxt_a, nxt_b);
    assign first_mask = pair_mask(idx_a[IDX_W-1:0], idx_b[IDX_W-1:0]);

    // Next-state and next-output decode; abort overrides everything.
    always_comb begin
        state_n    = state;
        led_n      = led;
        busy_n     = busy;
        done_n     = 1'b0;
        pair_num_n = pair_num;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        latch_en   = 1'b0;

        if (abort) begin
            state_n    = ST_IDLE;
            led_n      = '0;
            busy_n     = 1'b0;
            pair_num_n = 3'd0;
            tmr_load   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    led_n      = '0;
                    busy_n     = 1'b0;
                    pair_num_n = 3'd0;
                    if (start) begin
                        latch_en = 1'b1;
                        state_n  = ST_ON;
                        led_n    = first_mask;
                        busy_n   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (tmr_expired) begin
                        if (pair_num == LAST_PAIR) begin
                            state_n = ST_FIN;
                            led_n   = '0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
`ifdef FLASH_SEQ_GAP_EN
                            state_n  = ST_GAP;
                            led_n    = '0;
                            tmr_load = 1'b1;
                            tmr_val  = OFF_LOAD;
`else
                            pair_num_n = nxt_idx;
                            led_n      = nxt_mask;
                            tmr_load   = 1'b1;
                            tmr_val    = ON_LOAD;
`endif
                        end
                    end
                end
`ifdef FLASH_SEQ_GAP_EN
                ST_GAP: begin
                    if (tmr_expired) begin
                        state_n    = ST_ON;
                        pair_num_n = nxt_idx;
                        led_n      = nxt_mask;
                        tmr_load   = 1'b1;
                        tmr_val    = ON_LOAD;
                    end
                end
`endif
                ST_FIN: begin
                    state_n    = ST_IDLE;
                    led_n      = '0;
                    busy_n     = 1'b0;
                    pair_num_n = 3'd0;
                end
                default: begin
                    state_n    = ST_IDLE;
                    led_n      = '0;
                    busy_n     = 1'b0;
                    pair_num_n = 3'd0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pair_num <= 3'd0;
        end else begin
            state    <= state_n;
            led      <= led_n;
            busy     <= busy_n;
            done     <= done_n;
            pair_num <= pair_num_n;
        end
    end

    // Pair storage: captured once at start acceptance, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_a <= '0;
            lat_b <= '0;
        end else if (latch_en) begin
            lat_a <= idx_a;
            lat_b <= idx_b;
        end
    end

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench for flash_sequencer with ON=4, OFF=2, three pairs.
// Expected waveforms follow FLASH_SEQ_GAP_EN the same way the design does.
module tb_flash_sequencer;
    import memory_game_pkg::*;

    localparam int NP = 3;
    localparam int LW = 16;
    localparam int IW = 4;

    // Pairs (0,15),(3,4),(7,7)
    localparam logic [NP*IW-1:0] PAIR_A = {4'd7, 4'd3, 4'd0};
    localparam logic [NP*IW-1:0] PAIR_B = {4'd7, 4'd4, 4'd15};

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [NP*IW-1:0]  idx_a;
    logic [NP*IW-1:0]  idx_b;
    logic [LW-1:0]     led;
    logic              busy;
    logic              done;
    logic [2:0]        pair_num;
    flash_state_t      state;

    int n_checks;
    int n_errors;

    typedef struct {
        logic          start;
        logic [LW-1:0] led;
        logic          busy;
        logic          done;
        logic [2:0]    pnum;
    } vec_t;

    vec_t vecs[$];

    flash_sequencer #(
        .NUM_PAIRS  (NP),
        .LED_W      (LW),
        .IDX_W      (IW),
        .ON_CYCLES  (4),
        .OFF_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .idx_a    (idx_a),
        .idx_b    (idx_b),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .pair_num (pair_num),
        .state    (state)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_rows(input int n, input logic s, input logic [LW-1:0] l,
                            input logic b, input logic d, input logic [2:0] p);
        vec_t v;
        v.start = s;
        v.led   = l;
        v.busy  = b;
        v.done  = d;
        v.pnum  = p;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_led"},   32'(led),      32'h0);
        chk({tag, "_busy"},  32'(busy),     32'h0);
        chk({tag, "_done"},  32'(done),     32'h0);
        chk({tag, "_pnum"},  32'(pair_num), 32'h0);
        chk({tag, "_state"}, 32'(state),    32'(ST_IDLE));
    endtask

    // Play the table from an idle DUT; row i is the state after edge i.
    // perturb: garbage idx inputs after the latch and a second start at
    // edge 5. abort_at >= 0: assert abort for that edge and stop there.
    task automatic run_table(input string tag, input bit perturb, input int abort_at);
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < vecs.size() && !stop; i++) begin
            start = vecs[i].start;
            abort = 1'b0;
            idx_a = PAIR_A;
            idx_b = PAIR_B;
            if (perturb && i > 0) begin
                idx_a = 12'h5C9 ^ 12'(i);
                idx_b = 12'h2B6;
                if (i == 5) begin
                    start = 1'b1;
                    idx_a = 12'h123;
                    idx_b = 12'h456;
                end
                if (i >= 8) idx_a = 12'hFFF;
            end
            if (i == abort_at) abort = 1'b1;
            tick();
            if (i == abort_at) begin
                check_idle({tag, "_abort"});
                stop = 1'b1;
            end else begin
                chk($sformatf("%s_e%0d_led", tag, i),  32'(led),      32'(vecs[i].led));
                chk($sformatf("%s_e%0d_busy", tag, i), 32'(busy),     32'(vecs[i].busy));
                chk($sformatf("%s_e%0d_done", tag, i), 32'(done),     32'(vecs[i].done));
                chk($sformatf("%s_e%0d_pnum", tag, i), 32'(pair_num), 32'(vecs[i].pnum));
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idx_a = '0;
        idx_b = '0;

        // Expected trace for a full round starting at edge 0.
`ifdef FLASH_SEQ_GAP_EN
        add_rows(1, 1'b1, 16'h8001, 1'b1, 1'b0, 3'd0);
        add_rows(3, 1'b0, 16'h8001, 1'b1, 1'b0, 3'd0);
        add_rows(2, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0);
        add_rows(4, 1'b0, 16'h0018, 1'b1, 1'b0, 3'd1);
        add_rows(2, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd1);
        add_rows(4, 1'b0, 16'h0080, 1'b1, 1'b0, 3'd2);
        add_rows(1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd2);
        add_rows(1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
`else
        add_rows(1, 1'b1, 16'h8001, 1'b1, 1'b0, 3'd0);
        add_rows(3, 1'b0, 16'h8001, 1'b1, 1'b0, 3'd0);
        add_rows(4, 1'b0, 16'h0018, 1'b1, 1'b0, 3'd1);
        add_rows(4, 1'b0, 16'h0080, 1'b1, 1'b0, 3'd2);
        add_rows(1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd2);
        add_rows(1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
`endif

        // Reset values while reset is held.
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Basic round.
        run_table("basic", 1'b0, -1);

        // Abort while pair 1 is lit, then an immediate restart.
        run_table("abort", 1'b0, 8);
        run_table("restart", 1'b0, -1);

        // Re-start while busy and changing idx inputs mid-round.
        run_table("ignore", 1'b1, -1);

        // start and abort together in IDLE: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        idx_a = PAIR_A;
        idx_b = PAIR_B;
        tick();
        check_idle("start_abort");
        start = 1'b0;
        abort = 1'b0;
        tick();
        check_idle("start_abort_hold");

        // Asynchronous reset mid-round (edge 10: gap after pair 1, or pair 2 lit).
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        chk("pre_rst_busy", 32'(busy),     32'h1);
        chk("pre_rst_pnum", 32'(pair_num), 32'h1 + (`ifdef FLASH_SEQ_GAP_EN 32'h0 `else 32'h1 `endif));
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        #1;
        rst = 1'b0;
        tick();
        check_idle("after_rst");
        run_table("after_rst_round", 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flash_sequencer.md
# flash_sequencer

- Controller that plays the memorisation phase of the memory game.
- On `start` it latches NUM_PAIRS LED-index pairs and lights each pair on the red LED bank for a programmed on-time, separated by off-gaps.
- It then pulses `done`, so the game FSM can move to switch entry.
- It owns the red LEDs during flash; the game FSM only sequences it via `start`, `abort` and `done`.

## Interface
- NUM_PAIRS, 3, number of pairs flashed per round (1..8)
- LED_W, 16, LED bank width; must equal 2**IDX_W
- IDX_W, 4, width of one LED index
- ON_CYCLES, 50_000_000, clock cycles each pair is lit (≥1)
- OFF_CYCLES, 12_500_000, clock cycles of dark gap between pairs (≥1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a round; sampled only in IDLE
- abort  in  1  cancel round (game timeout); any state
- idx_a  in  NUM_PAIRS*IDX_W  first LED index of each pair; pair k at bits [k*IDX_W +: IDX_W]
- idx_b  in  NUM_PAIRS*IDX_W  second LED index of each pair, same packing
- led  out  LED_W  red LED drive
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when the last pair has finished
- pair_num  out  3  index of pair currently lit (0 when idle)

## Operation
- Reset values: led=0, busy=0, done=0, pair_num=0, state=IDLE, timer=0.
- States: IDLE, ON, GAP, FIN.
- IDLE:
  - If start=1 and abort=0: latch idx_a/idx_b into internal registers, set pair_num=0, led=onehot(a0)|onehot(b0), load timer with ON_CYCLES-1, go to ON.
  - Inputs idx_a/idx_b are ignored after the latch.
- ON: timer decrements each cycle. When timer=0:
  - If pair_num==NUM_PAIRS-1: led=0, go to FIN.
  - Otherwise: led=0, load OFF_CYCLES-1, go to GAP.
- GAP: when timer=0, pair_num+=1, led=mask of the new pair, load ON_CYCLES-1, go to ON.
- FIN: done=1 and busy=0 for exactly this cycle; go to IDLE.
- Mask rule: led=(1<<a)|(1<<b). If a==b, exactly one LED is lit. Out-of-range indices are impossible because LED_W=2**IDX_W.
- start while busy: ignored, with no queuing.
- abort=1 in ON, GAP or FIN: next state IDLE, led=0, busy=0, pair_num=0, no done pulse. Abort has priority over every timer expiry and over start.
- rst asserted mid-round: immediate return to reset values, including clearing the latched pairs.
- Timer width: $clog2(max(ON_CYCLES, OFF_CYCLES)+1), unsigned, with no wrap. It is reloaded before it can underflow.

## Timing
- Start accepted at edge 0: led shows pair 0 and busy=1 from edge 0.
- Pair k lit from edge k*(ON+OFF) for ON cycles.
- Gap k from edge k*(ON+OFF)+ON for OFF cycles.
- led=0 and done=1 from edge N*ON+(N-1)*OFF (N=NUM_PAIRS) for one cycle.
- A new start is accepted at the edge after the done cycle at the earliest.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- FLASH_SEQ_GAP_EN defined: GAP state is present as described above.
- Not defined:
  - GAP state is removed and OFF_CYCLES is unused.
  - The next pair's mask is driven at the same edge the previous on-time expires.
  - Done occurs at edge N*ON.

## Structure
- Shared package memory_game_pkg holds:
  - Flash state enum (IDLE/ON/GAP/FIN, 2-bit).
  - LED_W/IDX_W defaults.
  - A function `pair_mask(a,b)` returning the LED_W one-hot OR, also used by the game FSM for switch comparison.
- One sub-module, flash_timer: loadable down-counter with ports load, load_val, expired (timer==0). It is reused for both the on-time and the gap.

## Test plan
Benches use ON_CYCLES=4, OFF_CYCLES=2, NUM_PAIRS=3.
- Pairs (0,15),(3,4),(7,7), start pulse at edge 0 -> led:
  - 0x8001 edges 0–3, 0 edges 4–5
  - 0x0018 edges 6–9, 0 edges 10–11
  - 0x0080 edges 12–15
  - done=1 only at edge 16; busy low at 16.
- Same stimulus, FLASH_SEQ_GAP_EN undefined -> 0x8001 at 0–3, 0x0018 at 4–7, 0x0080 at 8–11, done at edge 12.
- abort at edge 7 (pair 1 lit) -> led=0, busy=0 at edge 8. done never asserts; restart at edge 9 replays from pair 0.
- start re-pulsed at edge 5 with different idx inputs, and idx_a changed mid-round -> ignored; sequence identical to the first scenario.
- rst asserted asynchronously mid-GAP -> led, busy and pair_num drop to 0 without waiting for clk; first start after release behaves as the first scenario.
- start and abort both high in IDLE -> remains IDLE, led=0, busy=0.
